game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - screen sequencing for a two-player game: start menu, play, result hold and rematch
module game_state_ctrl #(
  parameter int         WIN_POINTS  = 10,
  parameter logic [7:0] START_KEY   = 8'h5A,
  parameter logic [7:0] ABORT_KEY   = 8'h76,
  parameter int         RESULT_HOLD = 130_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic [4:0]  points_1,
  input  logic [4:0]  points_2,
  output logic [1:0]  screen,
  output logic        game_rst,
  output logic        hold_done
);

  localparam int            CW       = $clog2(RESULT_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(RESULT_HOLD - 1);
  localparam logic [31:0]   WIN_U    = 32'(WIN_POINTS);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_GAME  = 2'd1,
    S_P1    = 2'd2,
    S_P2    = 2'd3
  } state_t;

  state_t        state_q, state_next;
  logic [CW-1:0] hold_cnt;

  logic start_raw, abort_raw;
  logic start_held, start_prev, start_block;
  logic abort_held, abort_prev, abort_block;
  logic start_ev, abort_ev;
  logic win_1, win_2, in_result;

  assign start_raw = (keycode[7:0] == START_KEY) && (keycode[15:8] != 8'hF0);
  assign abort_raw = (keycode[7:0] == ABORT_KEY) && (keycode[15:8] != 8'hF0);

  // The block flags suppress a key that was already down when reset released;
  // they clear only once that key has been seen released.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_held  <= 1'b0;
      start_prev  <= 1'b0;
      start_block <= 1'b1;
      abort_held  <= 1'b0;
      abort_prev  <= 1'b0;
      abort_block <= 1'b1;
    end else begin
      start_held  <= start_raw;
      start_prev  <= start_held;
      start_block <= start_block & start_raw;
      abort_held  <= abort_raw;
      abort_prev  <= abort_held;
      abort_block <= abort_block & abort_raw;
    end
  end

  assign start_ev = start_held & ~start_prev & ~start_block;
  assign abort_ev = abort_held & ~abort_prev & ~abort_block;

  assign win_1     = {27'd0, points_1} >= WIN_U;
  assign win_2     = {27'd0, points_2} >= WIN_U;
  assign in_result = (state_q == S_P1) || (state_q == S_P2);
  assign hold_done = in_result && (hold_cnt == HOLD_MAX);
  assign screen    = state_q;

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_START: if (start_ev) state_next = S_GAME;
      S_GAME: begin
        if (win_1)         state_next = S_P1;
        else if (win_2)    state_next = S_P2;
        else if (abort_ev) state_next = S_START;
      end
      default: begin
        if (hold_done) begin
          if (start_ev)      state_next = S_GAME;
          else if (abort_ev) state_next = S_START;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      game_rst <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_next;
      game_rst <= (state_next != S_GAME);
      // Count only while staying in the same result state; entry and exit zero it.
      if ((state_next == S_P1 || state_next == S_P2) && state_next == state_q) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CW'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule
